// File: rtl/usb_uart_rxbuf.sv
// Receive FIFO for bridge-delivered UART bytes: index-change push, show-ahead read, sticky flags.
// Optional level interrupt is built when USB_UART_RXBUF_IRQ_EN is defined.
module usb_uart_rxbuf #(
    parameter int ADDR_WIDTH = 8,
    parameter int IRQ_LEVEL  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic [7:0]            rx_idx,
    input  logic                  rd,
    input  logic                  clr,
    output logic [7:0]            dout,
    output logic                  rx_empty,
    output logic                  rx_full,
    output logic [ADDR_WIDTH:0]   rx_count,
    output logic                  rx_ovf,
    output logic                  rx_lost,
    output logic                  irq
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    if (IRQ_LEVEL < 1 || IRQ_LEVEL > DEPTH) begin : g_bad_level
        $error("usb_uart_rxbuf: IRQ_LEVEL out of range");
    end

    logic [7:0]            mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [7:0]            prev_idx;
    logic                  armed;
    logic                  ovf;
    logic                  lost;

    logic idx_chg;
    logic push;
    logic gap;
    logic full;
    logic empty;
    logic do_pop;
    logic do_push;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign idx_chg = armed && (rx_idx != prev_idx);
    // clr swallows both the arriving byte and any pop in the same cycle
    assign push    = idx_chg && !clr;
    assign gap     = rx_idx != (prev_idx + 8'd1);
    assign do_pop  = rd && !empty && !clr;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed    <= 1'b0;
            prev_idx <= '0;
        end else begin
            armed    <= 1'b1;
            prev_idx <= rx_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            lost   <= 1'b0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            lost   <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push && !do_pop)
                count <= count + CNT_ONE;
            else if (do_pop && !do_push)
                count <= count - CNT_ONE;
            if (push && !do_push)
                ovf <= 1'b1;
            if (push && gap)
                lost <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= rx_data;
    end

    // Head slot is stale when empty, so present zero instead
    assign dout     = empty ? 8'h00 : mem[rd_ptr];
    assign rx_empty = empty;
    assign rx_full  = full;
    assign rx_count = count;
    assign rx_ovf   = ovf;
    assign rx_lost  = lost;

`ifdef USB_UART_RXBUF_IRQ_EN
    localparam logic [ADDR_WIDTH:0] LEVEL = (ADDR_WIDTH+1)'(IRQ_LEVEL);
    logic irq_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            irq_q <= 1'b0;
        else
            irq_q <= (count >= LEVEL) || ovf;
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_usb_uart_rxbuf.sv
// Directed bench for usb_uart_rxbuf (ADDR_WIDTH=4, IRQ_LEVEL=4).
// Vector table for single-cycle behaviour, hand sequences for full, irq and reset.
module tb_usb_uart_rxbuf;

    localparam int AW = 4;
`ifdef USB_UART_RXBUF_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic [7:0]  rx_idx;
    logic        rd;
    logic        clr;
    logic [7:0]  dout;
    logic        rx_empty;
    logic        rx_full;
    logic [AW:0] rx_count;
    logic        rx_ovf;
    logic        rx_lost;
    logic        irq;

    usb_uart_rxbuf #(.ADDR_WIDTH(AW), .IRQ_LEVEL(4)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_idx(rx_idx),
        .rd(rd), .clr(clr), .dout(dout), .rx_empty(rx_empty),
        .rx_full(rx_full), .rx_count(rx_count), .rx_ovf(rx_ovf),
        .rx_lost(rx_lost), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] idx;
        logic [7:0] data;
        logic       rd;
        logic       clr;
        logic [4:0] cnt;
        logic [7:0] dout;
        logic       ovf;
        logic       lost;
    } vec_t;

    vec_t vt [19];
    int   passed = 0;
    int   total  = 0;
    logic [4:0] last_cnt = '0;
    logic       last_ovf = 1'b0;

    function automatic vec_t mk(input logic [7:0] i, input logic [7:0] d,
                                input logic r, input logic c, input logic [4:0] n,
                                input logic [7:0] o, input logic v, input logic l);
        vec_t t;
        t.idx = i; t.data = d; t.rd = r; t.clr = c;
        t.cnt = n; t.dout = o; t.ovf = v; t.lost = l;
        return t;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_out(input string tag, input logic [4:0] n, input logic [7:0] o,
                             input logic v, input logic l);
        logic exp_irq;
        exp_irq = IRQ_EN && ((last_cnt >= 5'd4) || last_ovf);
        chk({tag, ".count"}, 16'(rx_count), 16'(n));
        chk({tag, ".dout"}, 16'(dout), 16'(o));
        chk({tag, ".empty"}, 16'(rx_empty), 16'(n == 5'd0));
        chk({tag, ".full"}, 16'(rx_full), 16'(n == 5'd16));
        chk({tag, ".ovf"}, 16'(rx_ovf), 16'(v));
        chk({tag, ".lost"}, 16'(rx_lost), 16'(l));
        chk({tag, ".irq"}, 16'(irq), 16'(exp_irq));
        last_cnt = n;
        last_ovf = v;
    endtask

    task automatic step(input string tag, input logic [7:0] i, input logic [7:0] d,
                        input logic r, input logic c, input logic [4:0] n,
                        input logic [7:0] o, input logic v, input logic l);
        rx_idx = i; rx_data = d; rd = r; clr = c;
        @(posedge clk);
        #1;
        check_out(tag, n, o, v, l);
    endtask

    initial begin
        reset = 1'b1; rx_idx = 8'h37; rx_data = 8'h00; rd = 1'b0; clr = 1'b0;
        vt[0]  = mk(8'h37, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        vt[1]  = mk(8'h38, 8'hA5, 0, 0, 1, 8'hA5, 0, 0);
        vt[2]  = mk(8'h38, 8'h00, 1, 0, 0, 8'h00, 0, 0);
        vt[3]  = mk(8'hFD, 8'h00, 0, 0, 1, 8'h00, 0, 1);
        vt[4]  = mk(8'hFD, 8'h00, 0, 1, 0, 8'h00, 0, 0);
        vt[5]  = mk(8'hFE, 8'h01, 0, 0, 1, 8'h01, 0, 0);
        vt[6]  = mk(8'hFF, 8'h02, 0, 0, 2, 8'h01, 0, 0);
        vt[7]  = mk(8'h00, 8'h03, 0, 0, 3, 8'h01, 0, 0);
        vt[8]  = mk(8'h00, 8'h00, 1, 0, 2, 8'h02, 0, 0);
        vt[9]  = mk(8'h00, 8'h00, 1, 0, 1, 8'h03, 0, 0);
        vt[10] = mk(8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 0);
        vt[11] = mk(8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 0);
        vt[12] = mk(8'h10, 8'h44, 0, 1, 0, 8'h00, 0, 0);
        vt[13] = mk(8'h13, 8'h55, 0, 0, 1, 8'h55, 0, 1);
        vt[14] = mk(8'h13, 8'h00, 1, 1, 0, 8'h00, 0, 0);
        vt[15] = mk(8'h14, 8'h66, 1, 0, 1, 8'h66, 0, 0);
        vt[16] = mk(8'h15, 8'h77, 1, 0, 1, 8'h77, 0, 0);
        vt[17] = mk(8'h15, 8'h00, 1, 0, 0, 8'h00, 0, 0);
        vt[18] = mk(8'h15, 8'h00, 0, 0, 0, 8'h00, 0, 0);

        @(posedge clk); @(posedge clk); #1;
        check_out("reset", 0, 8'h00, 0, 0);
        reset = 1'b0;

        for (int k = 0; k < 19; k++)
            step($sformatf("vec%0d", k), vt[k].idx, vt[k].data, vt[k].rd, vt[k].clr,
                 vt[k].cnt, vt[k].dout, vt[k].ovf, vt[k].lost);

        for (int k = 0; k < 16; k++)
            step($sformatf("fill%0d", k), 8'h16 + 8'(k), 8'h80 + 8'(k), 0, 0,
                 5'(k + 1), 8'h80, 0, 0);
        step("full_push_rd", 8'h26, 8'hEE, 1, 0, 16, 8'h81, 0, 0);
        step("full_drop", 8'h27, 8'hEF, 0, 0, 16, 8'h81, 1, 0);
        for (int j = 1; j <= 16; j++) begin
            logic [7:0] head;
            head = (j <= 14) ? 8'h81 + 8'(j) : (j == 15) ? 8'hEE : 8'h00;
            step($sformatf("drain%0d", j), 8'h27, 8'h00, 1, 0, 5'(16 - j), head, 1, 0);
        end

        step("clr_ovf", 8'h27, 8'h00, 0, 1, 0, 8'h00, 0, 0);
        step("idle0", 8'h27, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        for (int k = 1; k <= 4; k++)
            step($sformatf("irqfill%0d", k), 8'h27 + 8'(k), 8'(k), 0, 0,
                 5'(k), 8'h01, 0, 0);
        step("irq_rise", 8'h2B, 8'h00, 0, 0, 4, 8'h01, 0, 0);
        step("irq_rd", 8'h2B, 8'h00, 1, 0, 3, 8'h02, 0, 0);
        step("irq_fall", 8'h2B, 8'h00, 0, 0, 3, 8'h02, 0, 0);
        step("pre_rst", 8'h2C, 8'h99, 0, 0, 4, 8'h02, 0, 0);

        #2 reset = 1'b1;
        #1;
        last_cnt = '0; last_ovf = 1'b0;
        check_out("async_rst", 0, 8'h00, 0, 0);
        rx_idx = 8'h2D; rx_data = 8'h11;
        @(posedge clk); #1;
        check_out("in_rst", 0, 8'h00, 0, 0);
        reset = 1'b0;
        step("rearm", 8'h2D, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        step("post_rst", 8'h2E, 8'hAB, 0, 0, 1, 8'hAB, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
